e_reg_pipe: RTL and testbench

Decode-to-execute pipeline register for the Y86-64 pipelined CPU. It sits directly downstream of the decode stage's register-file read and forward logic. It captures the decoded instruction fields and the operand values `d_valA`/`d_valB` into the E stage on every clock. It also detects load/use hazards and branch mispredictions, and inserts bubbles (NOP) in response. A saturating bubble counter is provided for performance debug.

---
 rtl/e_reg_pipe.sv | 181 ++++++++++++++++++
 tb/tb_e_reg_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_reg_pipe.sv
// -----------------------------------------------------------------------------
// e_reg_pipe
//
// Decode-to-execute pipeline register for the Y86-64 pipelined CPU.
// The decoded instruction fields are captured into the E stage on every
// rising clock edge. This block also detects two hazards: load/use, and a
// mispredicted conditional jump sitting in E. When a hazard is present, or
// when an external bubble is forced, it inserts a NOP bubble into E. A
// saturating counter records how many bubbles were inserted, for
// performance debug.
//
// Ports
//   clk_i                  clock, all state changes on the rising edge
//   rst_i                  synchronous reset, active-high
//   d_stat_i .. d_srcB_i   decode-stage fields (valA/valB already forwarded)
//   e_Cnd_i                condition outcome for the instruction now in E
//   ext_stall_i            hold the E contents (downstream back-pressure)
//   ext_bubble_i           force a bubble (exception further down the pipe)
//   E_*_o                  registered E-stage fields
//   load_use_o             load/use hazard; F and D must stall this cycle
//   mispredict_o           the jump in E was mispredicted
//   bubble_cnt_o           bubbles inserted since reset, saturating
// -----------------------------------------------------------------------------
module e_reg_pipe #(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        d_stat_i,
  input  logic [3:0]        d_icode_i,
  input  logic [3:0]        d_ifun_i,
  input  logic [63:0]       d_valC_i,
  input  logic [63:0]       d_valA_i,
  input  logic [63:0]       d_valB_i,
  input  logic [3:0]        d_dstE_i,
  input  logic [3:0]        d_dstM_i,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  input  logic              e_Cnd_i,
  input  logic              ext_stall_i,
  input  logic              ext_bubble_i,
  output logic [2:0]        E_stat_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [63:0]       E_valC_o,
  output logic [63:0]       E_valA_o,
  output logic [63:0]       E_valB_o,
  output logic [3:0]        E_dstE_o,
  output logic [3:0]        E_dstM_o,
  output logic [3:0]        E_srcA_o,
  output logic [3:0]        E_srcB_o,
  output logic              load_use_o,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Y86-64 encodings used by the hazard logic and the bubble value.
  localparam logic [2:0] STAT_AOK     = 3'd1;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE     = 4'hF;

  // All E-stage fields travel together. Grouping them means that hold, load
  // and bubble are each a single assignment, and no field can be missed.
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_stage_t;

  localparam e_stage_t E_BUBBLE = '{
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    ifun:  4'h0,
    valC:  64'd0,
    valA:  64'd0,
    valB:  64'd0,
    dstE:  REG_NONE,
    dstM:  REG_NONE,
    srcA:  REG_NONE,
    srcB:  REG_NONE
  };

  e_stage_t          e_q, e_d;
  e_stage_t          d_fields;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              e_is_load;
  logic              load_use;
  logic              mispredict;
  logic              bubble_req;
  logic              cnt_sat;

  assign d_fields = '{
    stat:  d_stat_i,
    icode: d_icode_i,
    ifun:  d_ifun_i,
    valC:  d_valC_i,
    valA:  d_valA_i,
    valB:  d_valB_i,
    dstE:  d_dstE_i,
    dstM:  d_dstM_i,
    srcA:  d_srcA_i,
    srcB:  d_srcB_i
  };

  // Hazard detection looks only at the registered E contents and the
  // current decode sources. It stays valid while E is stalled, because the
  // held contents re-create the same hazard on the next cycle. It is also
  // quiet after reset, because the bubble value has icode NOP and dstM = none.
  assign e_is_load  = (e_q.icode == ICODE_MRMOVQ) || (e_q.icode == ICODE_POPQ);

  // An instruction with no register destination (dstM = 4'hF) never causes
  // a load/use hazard. This holds even when a decode source is also 4'hF.
  assign load_use   = e_is_load
                      && (e_q.dstM != REG_NONE)
                      && ((e_q.dstM == d_srcA_i) || (e_q.dstM == d_srcB_i));

  // A jump is predicted taken. So the prediction was wrong if the condition
  // computed in execute turns out to be false.
  assign mispredict = (e_q.icode == ICODE_JXX) && !e_Cnd_i;

  assign bubble_req = ext_bubble_i || load_use || mispredict;
  assign cnt_sat    = &cnt_q;

  // Priority: stall, then bubble, then load. Reset is handled in the
  // register process, so it overrides everything here.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // block leaves it unassigned and no latch can be inferred.
    e_d   = e_q;
    cnt_d = cnt_q;
    if (ext_stall_i) begin
      e_d   = e_q;
      cnt_d = cnt_q;
    end else if (bubble_req) begin
      e_d = E_BUBBLE;
      if (!cnt_sat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      e_d = d_fields;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples its pre-edge value, whatever the statement order.
    if (rst_i) begin
      e_q   <= E_BUBBLE;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign E_stat_o     = e_q.stat;
  assign E_icode_o    = e_q.icode;
  assign E_ifun_o     = e_q.ifun;
  assign E_valC_o     = e_q.valC;
  assign E_valA_o     = e_q.valA;
  assign E_valB_o     = e_q.valB;
  assign E_dstE_o     = e_q.dstE;
  assign E_dstM_o     = e_q.dstM;
  assign E_srcA_o     = e_q.srcA;
  assign E_srcB_o     = e_q.srcB;
  assign load_use_o   = load_use;
  assign mispredict_o = mispredict;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_e_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_e_reg_pipe
//
// Self-checking bench for e_reg_pipe. It uses two instances that share
// their inputs: one with the default 16-bit counter, and one with a 4-bit
// counter so that saturation can be reached quickly. A small reference
// model holds the expected E contents and the expected counter values.
// -----------------------------------------------------------------------------
module tb_e_reg_pipe;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_t;

  localparam e_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, valC: 64'd0,
                            valA: 64'd0, valB: 64'd0, dstE: 4'hF, dstM: 4'hF,
                            srcA: 4'hF, srcB: 4'hF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, e_cnd, stall, bubble;
  e_t   d_in;

  // Outputs of the default-width instance.
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        lu, mp;
  logic [15:0] cnt16;
  // Outputs of the 4-bit-counter instance.
  logic [2:0]  s_stat;
  logic [3:0]  s_icode, s_ifun, s_dstE, s_dstM, s_srcA, s_srcB;
  logic [63:0] s_valC, s_valA, s_valB;
  logic        s_lu, s_mp;
  logic [3:0]  cnt4;

  e_t dut_e, sat_e;
  assign dut_e = {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
  assign sat_e = {s_stat, s_icode, s_ifun, s_valC, s_valA, s_valB, s_dstE, s_dstM, s_srcA, s_srcB};

  e_reg_pipe dut (
    .clk_i(clk), .rst_i(rst),
    .d_stat_i(d_in.stat), .d_icode_i(d_in.icode), .d_ifun_i(d_in.ifun),
    .d_valC_i(d_in.valC), .d_valA_i(d_in.valA), .d_valB_i(d_in.valB),
    .d_dstE_i(d_in.dstE), .d_dstM_i(d_in.dstM), .d_srcA_i(d_in.srcA), .d_srcB_i(d_in.srcB),
    .e_Cnd_i(e_cnd), .ext_stall_i(stall), .ext_bubble_i(bubble),
    .E_stat_o(E_stat), .E_icode_o(E_icode), .E_ifun_o(E_ifun),
    .E_valC_o(E_valC), .E_valA_o(E_valA), .E_valB_o(E_valB),
    .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB),
    .load_use_o(lu), .mispredict_o(mp), .bubble_cnt_o(cnt16)
  );

  e_reg_pipe #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .d_stat_i(d_in.stat), .d_icode_i(d_in.icode), .d_ifun_i(d_in.ifun),
    .d_valC_i(d_in.valC), .d_valA_i(d_in.valA), .d_valB_i(d_in.valB),
    .d_dstE_i(d_in.dstE), .d_dstM_i(d_in.dstM), .d_srcA_i(d_in.srcA), .d_srcB_i(d_in.srcB),
    .e_Cnd_i(e_cnd), .ext_stall_i(stall), .ext_bubble_i(bubble),
    .E_stat_o(s_stat), .E_icode_o(s_icode), .E_ifun_o(s_ifun),
    .E_valC_o(s_valC), .E_valA_o(s_valA), .E_valB_o(s_valB),
    .E_dstE_o(s_dstE), .E_dstM_o(s_dstM), .E_srcA_o(s_srcA), .E_srcB_o(s_srcB),
    .load_use_o(s_lu), .mispredict_o(s_mp), .bubble_cnt_o(cnt4)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  e_t m_e;
  int m_cnt16;
  int m_cnt4;

  function automatic logic model_load_use(e_t e, logic [3:0] sa, logic [3:0] sb);
    return ((e.icode == 4'h5) || (e.icode == 4'hB)) && (e.dstM != 4'hF)
           && ((e.dstM == sa) || (e.dstM == sb));
  endfunction

  function automatic logic model_mispredict(e_t e, logic cnd);
    return (e.icode == 4'h7) && !cnd;
  endfunction

  function automatic logic [3:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  function automatic e_t rand_instr();
    e_t x;
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       x.icode = 4'h5;
      1:       x.icode = 4'hB;
      2:       x.icode = 4'h7;
      3:       x.icode = 4'h6;
      default: x.icode = 4'($urandom_range(0, 15));
    endcase
    x.stat = 3'($urandom_range(1, 4));
    x.ifun = 4'($urandom_range(0, 15));
    x.valC = {$urandom(), $urandom()};
    x.valA = {$urandom(), $urandom()};
    x.valB = {$urandom(), $urandom()};
    x.dstE = rand_reg();
    x.dstM = rand_reg();
    x.srcA = rand_reg();
    x.srcB = rand_reg();
    return x;
  endfunction

  // Advance one clock. The model's next state is computed from the inputs
  // as they stand before the edge. Outputs can be read on return (#1 after
  // the edge), and the caller may then drive new inputs.
  task automatic tick();
    logic req;
    req = bubble || model_load_use(m_e, d_in.srcA, d_in.srcB) || model_mispredict(m_e, e_cnd);
    if (rst) begin
      m_e = BUBBLE; m_cnt16 = 0; m_cnt4 = 0;
    end else if (!stall) begin
      if (req) begin
        m_e = BUBBLE;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end else begin
        m_e = d_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; bubble = 1'b1; e_cnd = 1'($urandom());
    d_in = rand_instr();
    tick();
    d_in = rand_instr();
    tick();
    if (dut_e !== BUBBLE) begin
      n_err++; $display("FAIL reset_e: got %h want %h", dut_e, BUBBLE);
    end
    n_cmp++;
    if (cnt16 !== 16'd0 || cnt4 !== 4'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt16, cnt4);
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      d_in.srcA = 4'($urandom_range(0, 15)); d_in.srcB = 4'hF; e_cnd = 1'($urandom());
      #1;
      if (lu !== 1'b0 || mp !== 1'b0) begin
        n_err++; $display("FAIL reset_hazard: got lu=%b mp=%b want 0 0", lu, mp);
      end
      n_cmp++;
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_pass_through();
    d_in = '{stat: 3'd1, icode: 4'h6, ifun: 4'h0, valC: 64'h0, valA: 64'd5, valB: 64'd7,
             dstE: 4'h3, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};
    tick();
    if (E_icode !== 4'h6 || E_valA !== 64'd5 || E_valB !== 64'd7 || E_dstE !== 4'h3) begin
      n_err++; $display("FAIL pass_fields: got icode=%h valA=%0d valB=%0d dstE=%h want 6 5 7 3",
                        E_icode, E_valA, E_valB, E_dstE);
    end
    n_cmp++;
    if (cnt16 !== 16'd0) begin
      n_err++; $display("FAIL pass_cnt: got %0d want 0", cnt16);
    end
    n_cmp++;
  endtask

  task automatic test_load_use();
    d_in = '{stat: 3'd1, icode: 4'h5, ifun: 4'h0, valC: 64'h10, valA: 64'h0, valB: 64'h8,
             dstE: 4'hF, dstM: 4'h2, srcA: 4'hF, srcB: 4'h4};
    tick();
    d_in = '{stat: 3'd1, icode: 4'h6, ifun: 4'h0, valC: 64'h0, valA: 64'h1, valB: 64'h2,
             dstE: 4'h4, dstM: 4'hF, srcA: 4'hF, srcB: 4'h4};
    #1;
    if (lu !== 1'b0) begin
      n_err++; $display("FAIL lu_no_match: got %b want 0", lu);
    end
    n_cmp++;
    d_in.srcA = 4'h2;
    #1;
    if (lu !== 1'b1) begin
      n_err++; $display("FAIL lu_detect: got %b want 1", lu);
    end
    n_cmp++;
    tick();
    if (E_icode !== 4'h1 || cnt16 !== 16'd1 || lu !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble: got icode=%h cnt=%0d lu=%b want 1 1 0", E_icode, cnt16, lu);
    end
    n_cmp++;
  endtask

  task automatic test_mispredict();
    int c0;
    c0 = m_cnt16;
    d_in = rand_instr(); d_in.icode = 4'h7; d_in.dstM = 4'hF;
    tick();
    d_in = rand_instr(); d_in.icode = 4'h6;
    e_cnd = 1'b0;
    #1;
    if (mp !== 1'b1) begin
      n_err++; $display("FAIL mp_detect: got %b want 1", mp);
    end
    n_cmp++;
    tick();
    if (E_icode !== 4'h1 || cnt16 !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL mp_bubble: got icode=%h cnt=%0d want 1 %0d", E_icode, cnt16, c0 + 1);
    end
    n_cmp++;
    d_in = rand_instr(); d_in.icode = 4'h7; d_in.dstM = 4'hF;
    tick();
    d_in = rand_instr(); d_in.icode = 4'h2; d_in.dstM = 4'hF;
    e_cnd = 1'b1;
    #1;
    if (mp !== 1'b0) begin
      n_err++; $display("FAIL mp_taken: got %b want 0", mp);
    end
    n_cmp++;
    tick();
    if (dut_e !== d_in) begin
      n_err++; $display("FAIL mp_taken_load: got %h want %h", dut_e, d_in);
    end
    n_cmp++;
  endtask

  task automatic test_stall_vs_bubble();
    e_t held;
    int c0;
    held = m_e; c0 = m_cnt16;
    stall = 1'b1; bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = rand_instr();
      tick();
      if (dut_e !== held || cnt16 !== 16'(c0)) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h cnt=%0d want %h cnt=%0d",
                          i, dut_e, cnt16, held, c0);
      end
      n_cmp++;
    end
    stall = 1'b0;
    tick();
    if (dut_e !== BUBBLE || cnt16 !== 16'(c0 + 1)) begin
      n_err++; $display("FAIL stall_release: got %h cnt=%0d want %h cnt=%0d",
                        dut_e, cnt16, BUBBLE, c0 + 1);
    end
    n_cmp++;
    bubble = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0; bubble = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      d_in = rand_instr();
      tick();
      if (cnt4 !== 4'((i < 15) ? i : 15) || cnt16 !== 16'(i)) begin
        n_err++; $display("FAIL sat[%0d]: got %0d/%0d want %0d/%0d",
                          i, cnt4, cnt16, (i < 15) ? i : 15, i);
      end
      n_cmp++;
    end
    rst = 1'b1;
    tick();
    if (cnt4 !== 4'd0 || cnt16 !== 16'd0) begin
      n_err++; $display("FAIL sat_reset: got %0d/%0d want 0/0", cnt4, cnt16);
    end
    n_cmp++;
    rst = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      d_in   = rand_instr();
      e_cnd  = 1'($urandom());
      stall  = ($urandom_range(0, 4) == 0);
      bubble = ($urandom_range(0, 6) == 0);
      rst    = ($urandom_range(0, 49) == 0);
      #1;
      if (lu !== model_load_use(m_e, d_in.srcA, d_in.srcB) || mp !== model_mispredict(m_e, e_cnd)) begin
        n_err++; $display("FAIL rand_hazard[%0d]: got lu=%b mp=%b want %b %b", i, lu, mp,
                          model_load_use(m_e, d_in.srcA, d_in.srcB), model_mispredict(m_e, e_cnd));
      end
      n_cmp++;
      tick();
      if (dut_e !== m_e || sat_e !== m_e) begin
        n_err++; $display("FAIL rand_e[%0d]: got %h / %h want %h", i, dut_e, sat_e, m_e);
      end
      n_cmp++;
      if (cnt16 !== 16'(m_cnt16) || cnt4 !== 4'(m_cnt4)) begin
        n_err++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt16, cnt4, m_cnt16, m_cnt4);
      end
      n_cmp++;
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  // Reset asserted while stall and bubble are also active must still win.
  task automatic test_reset_override();
    d_in = rand_instr(); d_in.icode = 4'h6;
    tick();
    bubble = 1'b1;
    tick();
    rst = 1'b1; stall = 1'b1; bubble = 1'b1;
    d_in = rand_instr();
    tick();
    if (dut_e !== BUBBLE || cnt16 !== 16'd0) begin
      n_err++; $display("FAIL rst_override: got %h cnt=%0d want %h cnt=0", dut_e, cnt16, BUBBLE);
    end
    n_cmp++;
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; e_cnd = 1'b0;
    d_in = BUBBLE; m_e = BUBBLE; m_cnt16 = 0; m_cnt4 = 0;
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_load_use();
    test_mispredict();
    test_stall_vs_bubble();
    test_saturation();
    test_random();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
